// File: rtl/bmem_arbiter.sv
// bmem_arbiter: shares one banked-memory port between I and D line clients.
// Reads go out as single-cycle commands, D writes as BEATS-long bursts.
module bmem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [31:0]           d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [31:0]           bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LBYTES = LINE_WIDTH / 8;

    localparam logic [31:0]   LINE_MASK = ~(32'(LBYTES) - 32'd1);
    localparam logic [CW-1:0] LAST      = CW'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            i_state;
    logic [31:0]           i_line;
    logic [CW-1:0]         i_cnt;

    logic [1:0]            d_state;
    logic [31:0]           d_line;
    logic                  d_wr;
    logic [LINE_WIDTH-1:0] d_buf;
    logic [CW-1:0]         d_cnt;

    logic                  burst;
    logic [CW-1:0]         burst_idx;
    logic                  prio_d;

    logic                  can_start;
    logic                  grant_i;
    logic                  grant_d;
    logic                  burst_end;
    logic                  i_hit;
    logic                  d_hit;
    logic [31:0]           r_line;

    // Arbitration and response matching, all from registered state
    always_comb begin
        can_start = bmem_ready && !burst;
        grant_d   = can_start && (d_state == PEND)
                    && ((i_state != PEND) || prio_d);
        grant_i   = can_start && (i_state == PEND)
                    && ((d_state != PEND) || !prio_d);
        burst_end = burst && (burst_idx == LAST);
        r_line    = bmem_raddr & LINE_MASK;
        i_hit     = bmem_rvalid && (i_state == RWAIT) && (r_line == i_line);
        d_hit     = bmem_rvalid && (d_state == RWAIT) && (r_line == d_line);
    end

    // Command bus: running burst first, then the current grant
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        if (burst) begin
            bmem_write = 1'b1;
            bmem_addr  = d_line;
            bmem_wdata = d_buf[burst_idx*BEAT_WIDTH +: BEAT_WIDTH];
        end else if (grant_d) begin
            bmem_addr = d_line;
            if (d_wr) begin
                bmem_write = 1'b1;
                bmem_wdata = d_buf[0 +: BEAT_WIDTH];
            end else begin
                bmem_read = 1'b1;
            end
        end else if (grant_i) begin
            bmem_read = 1'b1;
            bmem_addr = i_line;
        end
    end

    // Write burst sequencer; beat 0 goes out with the grant itself
    always_ff @(posedge clk) begin
        if (rst) begin
            burst     <= 1'b0;
            burst_idx <= '0;
        end else if (burst) begin
            burst_idx <= burst_idx + 1'b1;
            if (burst_idx == LAST) begin
                burst <= 1'b0;
            end
        end else if (grant_d && d_wr) begin
            burst     <= 1'b1;
            burst_idx <= CW'(1);
        end
    end

    // Round-robin: the loser of a grant gets priority next time
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_d <= 1'b1;
        end else if (grant_d) begin
            prio_d <= 1'b0;
        end else if (grant_i) begin
            prio_d <= 1'b1;
        end
    end

    // I client: latch request, wait for grant, collect beats, pulse resp
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state <= IDLE;
            i_line  <= '0;
            i_cnt   <= '0;
            i_rdata <= '0;
            i_resp  <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            case (i_state)
                IDLE: begin
                    if (i_read) begin
                        i_line  <= i_addr & LINE_MASK;
                        i_state <= PEND;
                    end
                end
                PEND: begin
                    if (grant_i) begin
                        i_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (i_hit) begin
                        i_rdata[i_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        i_cnt <= i_cnt + 1'b1;
                        if (i_cnt == LAST) begin
                            i_state <= DONE;
                            i_resp  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    i_state <= IDLE;
                end
                default: begin
                    i_state <= IDLE;
                end
            endcase
        end
    end

    // D client: as I, plus writes that finish when the burst ends
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= IDLE;
            d_line  <= '0;
            d_wr    <= 1'b0;
            d_buf   <= '0;
            d_cnt   <= '0;
            d_rdata <= '0;
            d_resp  <= 1'b0;
        end else begin
            d_resp <= 1'b0;
            case (d_state)
                IDLE: begin
                    if (d_read || d_write) begin
                        d_line  <= d_addr & LINE_MASK;
                        d_wr    <= d_write;
                        d_buf   <= d_wdata;
                        d_state <= PEND;
                    end
                end
                PEND: begin
                    if (burst_end) begin
                        d_state <= DONE;
                        d_resp  <= 1'b1;
                    end else if (grant_d && !d_wr) begin
                        d_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (d_hit) begin
                        d_rdata[d_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                        d_cnt <= d_cnt + 1'b1;
                        if (d_cnt == LAST) begin
                            d_state <= DONE;
                            d_resp  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    d_state <= IDLE;
                end
                default: begin
                    d_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Arbitrates the instruction-cache and data-cache line ports onto the CPU's single banked-memory (bmem) port. It sits between the cache hierarchy inside `cpu` and the external DRAM controller. It serialises 256-bit line writes into 64-bit bursts and issues single-cycle read commands. It steers tagged read-response beats back into per-client line buffers.

## Interface
Parameters:
- `LINE_WIDTH`, 256: cache line width in bits.
- `BEAT_WIDTH`, 64: bmem data width. `BEATS = LINE_WIDTH/BEAT_WIDTH`, which is 4 and must be a power of two.

Ports:
- `clk` input 1: sole clock. Everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `i_addr` input 32: I-client line address. The low log2(LINE_WIDTH/8) bits are ignored.
- `i_read` input 1: I-client read request. It is held until `i_resp`.
- `i_rdata` output LINE_WIDTH: I-client read line.
- `i_resp` output 1: I-client completion pulse.
- `d_addr` input 32: D-client line address.
- `d_read` input 1: D-client read request.
- `d_write` input 1: D-client write request. `d_read` and `d_write` are never both high.
- `d_wdata` input LINE_WIDTH: D-client write line.
- `d_rdata` output LINE_WIDTH: D-client read line.
- `d_resp` output 1: D-client completion pulse.
- `bmem_addr` output 32: command address. It is line-aligned, with the low bits forced to 0.
- `bmem_read` output 1: one-cycle read command.
- `bmem_write` output 1: write beat valid.
- `bmem_wdata` output BEAT_WIDTH: write beat.
- `bmem_ready` input 1: controller can accept a new command this cycle.
- `bmem_raddr` input 32: line address of the returning beat.
- `bmem_rdata` input BEAT_WIDTH: returning beat.
- `bmem_rvalid` input 1: returning beat valid.

## Operation
Each client has its own FSM with four states: IDLE, PEND, RWAIT and DONE.
- IDLE → PEND when the request is high. On that edge the block latches the address, the direction and (for D) `d_wdata`.
- PEND: the client competes for the bmem command slot.
  - A read that wins goes to RWAIT.
  - A write that wins starts a burst and goes to DONE after the last beat is issued.
- RWAIT: the client collects `BEATS` response beats, then goes to DONE.
- DONE: `x_resp` = 1 for exactly one cycle, then the FSM returns to IDLE. A request that is still high during DONE is not sampled. A new request is sampled in IDLE on the following cycle.

Command arbitration:
- At most one command starts per cycle, and only when `bmem_ready` = 1 and no write burst is in progress.
- When both clients are in PEND, round-robin decides the winner. A grant to one client gives the other client priority next time. After reset the D client has priority.
- Read command: `bmem_read` = 1 for one cycle with the latched address.
- Write burst: `bmem_write` = 1 for `BEATS` consecutive cycles. `bmem_addr` is held for the whole burst. Beat k carries `d_wdata[k*BEAT_WIDTH +: BEAT_WIDTH]`, sent in order 0 through 3.
  - `bmem_ready` is sampled only at beat 0.
  - During beats 1..3 the burst continues regardless of `bmem_ready`, and no read can be issued.
- When no command is active, `bmem_read`, `bmem_write`, `bmem_addr` and `bmem_wdata` = 0.

Response steering:
- A beat is accepted by a client when `bmem_rvalid` = 1, that client is in RWAIT, and the line address of `bmem_raddr` equals the client's latched address.
- Accepted beats fill the client's buffer slices in order 0..3, tracked by a 2-bit per-client counter that wraps to 0.
- If both clients are in RWAIT on the same line, both accept every beat.
- The four beats of one response arrive on consecutive cycles. Responses to different clients may return in either order relative to issue.
- A beat that matches no client in RWAIT is dropped and changes no state.

`x_rdata` is a register. It is updated only by accepted beats and is held stable from DONE until the next fill. A write's `d_rdata` is not modified.

## Timing
- All outputs reset to 0. The FSMs reset to IDLE, the beat counters to 0, and priority to D.
- Reset mid-operation abandons in-flight requests. Beats arriving after reset are dropped, because no client is in RWAIT.
- Command outputs are combinational from registered state and `bmem_ready`. `x_resp` and `x_rdata` are registered.
- Read with no contention: the request is first high in IDLE at cycle t, giving PEND at t+1.
  - `bmem_read` is asserted at t+1 if ready.
  - If the last accepted beat is at cycle r, `x_resp` is asserted at r+1 with the full line valid.
- Write with no contention: the request is first high at t.
  - Beats are issued at t+1..t+4 and `d_resp` is asserted at t+5.
- A PEND client stalls with no timeout while `bmem_ready` = 0.

## Test plan
- Single I read of 0x0000_1040: `bmem_read` pulses once with `bmem_addr` = 0x0000_1040. Beats 0x11..11, 0x22..22, 0x33..33 and 0x44..44 arrive with matching `bmem_raddr`. `i_rdata` = {0x44..44, 0x33..33, 0x22..22, 0x11..11} and `i_resp` pulses once, one cycle after the last beat.
- D write to 0x0000_2000 with `d_wdata` = {D3,D2,D1,D0}: `bmem_write` is high for 4 cycles carrying D0, D1, D2, D3 with the address held. `d_resp` is asserted 5 cycles after the request.
- I read and D read issued in the same cycle right after reset: D is issued first and I on the next cycle. Responses return I-then-D, and each client gets only its own line.
- D write burst in progress while an I read is pending and `bmem_ready` toggles 1,0,1,0: no `bmem_read` is asserted until the beat after D3.
- Stray `bmem_rvalid` with `bmem_raddr` = 0x0000_9000 while no client is outstanding: no `x_resp`, and `x_rdata` is unchanged.
- `rst` asserted while the I client is in RWAIT after 2 beats: all outputs are 0 on the next cycle. The remaining 2 beats are ignored, and a new I read then completes normally.
